lsu_split: RTL
==============

Name: lsu_split

Overview:
- Load/store sequencer that sits directly upstream of mem_ctl in the memory stage.
- Accepts one load/store request from execute over a valid/ready handshake.
- Drives mem_ctl's port: a single access when the request is contained in one 32-bit word, otherwise a sequence of byte accesses.
- Assembles and extends load data, then returns a response to writeback over valid/ready.

Parameters:
- MEM_BYTES, 4096: addressable bytes behind mem_ctl. Any access touching a byte at or above MEM_BYTES is an error.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_is_store  in  1  1=store, 0=load
- req_addr  in  32  byte address
- req_width  in  2  `MEM_BYTE / `MEM_HALF / `MEM_WORD (define.vh)
- req_unsigned  in  1  zero-extend load result
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  access out of range
- mem_is_store  out  1  to mem_ctl is_store
- mem_addr  out  32  to mem_ctl addr
- mem_access_width  out  2  to mem_ctl mem_access_width
- mem_is_load_unsigned  out  1  to mem_ctl is_load_unsigned
- mem_w_data  out  32  to mem_ctl w_data
- mem_r_data  in  32  from mem_ctl r_data. Combinational, valid in the same cycle as the address. mem_ctl commits stores on the rising edge.

Behaviour:
- Reset (async, immediate): state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; mem_is_store=0; mem_addr=0; mem_access_width=`MEM_WORD; mem_is_load_unsigned=0; mem_w_data=0.
  - Reset during SPLIT abandons the sequence; store bytes already committed remain in memory.
- FSM states: IDLE, SINGLE, SPLIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture all req_* fields plus byte counter cnt=0.
  - Transition:
    - if addr+size-1 >= MEM_BYTES: RESP with err=1 (no memory access);
    - else if crossing: SPLIT;
    - else: SINGLE.
  - Crossing rule: HALF with addr[1:0]==3; WORD with addr[1:0]!=0. BYTE never crosses.
- SINGLE, exactly one cycle:
  - mem port driven with captured addr/width/unsigned/wdata; mem_is_store=captured is_store.
  - Load: latch mem_r_data (already extended by mem_ctl) into result.
  - Go RESP.
- SPLIT, n cycles (n=2 for HALF, 4 for WORD):
  - Cycle cnt drives mem_addr=addr+cnt, mem_access_width=`MEM_BYTE, mem_is_load_unsigned=1, mem_w_data={24'b0, wdata[8*cnt+:8]}.
  - Load: result[8*cnt+:8]=mem_r_data[7:0].
  - cnt increments each cycle; after cnt==n-1, go RESP.
  - Little-endian byte order.
- RESP:
  - resp_valid=1.
  - resp_rdata = result, with SPLIT loads sign-extended from bit 15 (HALF) unless unsigned. WORD needs no extension.
  - Stores and errors: resp_rdata=0.
  - On resp_ready: go IDLE. req_ready stays 0 during the response cycle, so there is no back-to-back overlap.
- Outside SINGLE/SPLIT: mem_is_store=0 always, so no stray stores occur. Other mem_* outputs hold their last values.
- Latency, request accept to resp_valid: SINGLE 2 cycles; HALF split 3; WORD split 5; error 1.
- Address arithmetic is 32-bit; addr+cnt wrap past 2^32 is prevented by the range check.
- req_valid is ignored outside IDLE.
- resp_ready held low keeps RESP and all resp_* outputs stable indefinitely.

Test Plan:
- Aligned word store 0xDEADBEEF @0, then load word @0 -> each response 2 cycles after accept; load resp_rdata=0xDEADBEEF, resp_err=0; mem_is_store high for exactly one cycle.
- Store byte 0xFE @4, then signed/unsigned byte loads @4 -> 0xFFFFFFFE / 0x000000FE.
- Misaligned word store 0x11223344 @0x0D -> 4 byte stores to 0x0D..0x10 with data 44,33,22,11; word load @0x0D -> 0x11223344, latency 5.
- Half store 0x8001 @0x07 (crosses word) -> 2 byte stores; signed load -> 0xFFFF8001, unsigned -> 0x00008001.
- Word load @MEM_BYTES-2 -> resp_err=1, resp_rdata=0, no mem_is_store pulse, response 1 cycle after accept. Byte load @MEM_BYTES-1 -> err=0.
- Hold resp_ready=0 for 5 cycles -> resp_* stable and req_ready=0. Assert rst_n=0 mid-SPLIT store -> all outputs at reset values immediately; next request processed normally.

Source files
------------

// File: rtl/lsu_split.sv
// Load/store sequencer in front of mem_ctl: single access for word-contained requests,
// otherwise a little-endian series of byte accesses, then a valid/ready response.
module lsu_split #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_width,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_is_store,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_access_width,
  output logic        mem_is_load_unsigned,
  output logic [31:0] mem_w_data,
  input  logic [31:0] mem_r_data
);

  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  typedef enum logic [1:0] {IDLE, SINGLE, SPLIT, RESP} state_t;

  state_t      state_reg, state_next;
  logic        is_store_reg, is_store_next;
  logic [31:0] addr_reg, addr_next;
  logic [1:0]  width_reg, width_next;
  logic        uns_reg, uns_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [1:0]  cnt_reg, cnt_next;
  logic [31:0] result_reg, result_next;
  logic        err_reg, err_next;
  logic        split_reg, split_next;

  logic        mem_is_store_next;
  logic [31:0] mem_addr_next;
  logic [1:0]  mem_access_width_next;
  logic        mem_is_load_unsigned_next;
  logic [31:0] mem_w_data_next;
  logic        req_ready_next;
  logic        resp_valid_next;
  logic [31:0] resp_rdata_next;
  logic        resp_err_next;

  logic [2:0]  req_size;
  logic [32:0] req_last_byte;
  logic        req_oob;
  logic        req_cross;
  logic [1:0]  last_cnt;

  // Range check is done in 33 bits so addresses near 2^32 cannot wrap into range.
  always_comb begin
    case (req_width)
      MEM_BYTE: req_size = 3'd1;
      MEM_HALF: req_size = 3'd2;
      default:  req_size = 3'd4;
    endcase
    req_last_byte = {1'b0, req_addr} + {30'b0, req_size} - 33'd1;
    req_oob       = (req_last_byte >= 33'(MEM_BYTES));
    case (req_width)
      MEM_BYTE: req_cross = 1'b0;
      MEM_HALF: req_cross = (req_addr[1:0] == 2'd3);
      default:  req_cross = (req_addr[1:0] != 2'd0);
    endcase
    last_cnt = (width_reg == MEM_HALF) ? 2'd1 : 2'd3;
  end

  always_comb begin
    state_next    = state_reg;
    is_store_next = is_store_reg;
    addr_next     = addr_reg;
    width_next    = width_reg;
    uns_next      = uns_reg;
    wdata_next    = wdata_reg;
    cnt_next      = cnt_reg;
    result_next   = result_reg;
    err_next      = err_reg;
    split_next    = split_reg;

    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          is_store_next = req_is_store;
          addr_next     = req_addr;
          width_next    = req_width;
          uns_next      = req_unsigned;
          wdata_next    = req_wdata;
          cnt_next      = 2'd0;
          result_next   = 32'd0;
          err_next      = req_oob;
          split_next    = req_cross && !req_oob;
          if (req_oob)        state_next = RESP;
          else if (req_cross) state_next = SPLIT;
          else                state_next = SINGLE;
        end
      end
      SINGLE: begin
        if (!is_store_reg) result_next = mem_r_data;
        state_next = RESP;
      end
      SPLIT: begin
        if (!is_store_reg) result_next[{cnt_reg, 3'b000} +: 8] = mem_r_data[7:0];
        cnt_next = cnt_reg + 2'd1;
        if (cnt_reg == last_cnt) state_next = RESP;
      end
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs are computed for the state being entered, so the mem port is
  // already stable during the SINGLE/SPLIT cycle that samples mem_r_data.
  always_comb begin
    mem_is_store_next         = 1'b0;
    mem_addr_next             = mem_addr;
    mem_access_width_next     = mem_access_width;
    mem_is_load_unsigned_next = mem_is_load_unsigned;
    mem_w_data_next           = mem_w_data;
    req_ready_next            = (state_next == IDLE);
    resp_valid_next           = resp_valid;
    resp_rdata_next           = resp_rdata;
    resp_err_next             = resp_err;

    if (state_next == SINGLE) begin
      mem_is_store_next         = is_store_next;
      mem_addr_next             = addr_next;
      mem_access_width_next     = width_next;
      mem_is_load_unsigned_next = uns_next;
      mem_w_data_next           = wdata_next;
    end else if (state_next == SPLIT) begin
      mem_is_store_next         = is_store_next;
      mem_addr_next             = addr_next + {30'b0, cnt_next};
      mem_access_width_next     = MEM_BYTE;
      mem_is_load_unsigned_next = 1'b1;
      mem_w_data_next           = {24'b0, wdata_next[{cnt_next, 3'b000} +: 8]};
    end

    if (state_next == RESP && state_reg != RESP) begin
      resp_valid_next = 1'b1;
      resp_err_next   = err_next;
      if (is_store_next || err_next)
        resp_rdata_next = 32'd0;
      else if (split_next && width_next == MEM_HALF && !uns_next)
        resp_rdata_next = {{16{result_next[15]}}, result_next[15:0]};
      else
        resp_rdata_next = result_next;
    end else if (state_next == IDLE) begin
      resp_valid_next = 1'b0;
      resp_rdata_next = 32'd0;
      resp_err_next   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg            <= IDLE;
      is_store_reg         <= 1'b0;
      addr_reg             <= 32'd0;
      width_reg            <= MEM_WORD;
      uns_reg              <= 1'b0;
      wdata_reg            <= 32'd0;
      cnt_reg              <= 2'd0;
      result_reg           <= 32'd0;
      err_reg              <= 1'b0;
      split_reg            <= 1'b0;
      req_ready            <= 1'b1;
      resp_valid           <= 1'b0;
      resp_rdata           <= 32'd0;
      resp_err             <= 1'b0;
      mem_is_store         <= 1'b0;
      mem_addr             <= 32'd0;
      mem_access_width     <= MEM_WORD;
      mem_is_load_unsigned <= 1'b0;
      mem_w_data           <= 32'd0;
    end else begin
      state_reg            <= state_next;
      is_store_reg         <= is_store_next;
      addr_reg             <= addr_next;
      width_reg            <= width_next;
      uns_reg              <= uns_next;
      wdata_reg            <= wdata_next;
      cnt_reg              <= cnt_next;
      result_reg           <= result_next;
      err_reg              <= err_next;
      split_reg            <= split_next;
      req_ready            <= req_ready_next;
      resp_valid           <= resp_valid_next;
      resp_rdata           <= resp_rdata_next;
      resp_err             <= resp_err_next;
      mem_is_store         <= mem_is_store_next;
      mem_addr             <= mem_addr_next;
      mem_access_width     <= mem_access_width_next;
      mem_is_load_unsigned <= mem_is_load_unsigned_next;
      mem_w_data           <= mem_w_data_next;
    end
  end

endmodule
